// File: rtl/tdc_div_x400.sv
// Divides the summed 8-channel x50 TDC time word by a constant (400) using a
// sequential restoring divider, one quotient bit per clock, MSB first.
// A one-deep pending register absorbs a sample that arrives while busy.
//
// Ports:
//   clk_i        system clock, all logic on posedge
//   rst_ni       asynchronous active-low reset
//   in_data_i    summed time word from the accumulator
//   in_dval_i    in_data_i valid, one sample per high cycle
//   q_out_o      quotient (saturated to all-ones if it does not fit Q_W)
//   r_out_o      remainder, 0..DIVISOR-1
//   out_dval_o   one-cycle pulse, q_out_o/r_out_o/sat_o updated
//   sat_o        quotient of the current result exceeded 2**Q_W-1
//   busy_o       divider not idle
//   drop_o       one-cycle pulse, a sample was lost (pending already full)
//   drop_cnt_o   saturating count of dropped samples
module tdc_div_x400 #(
    parameter int unsigned IN_W    = 20,
    parameter int unsigned DIVISOR = 400,
    parameter int unsigned Q_W     = 12,
    parameter int unsigned R_W     = 9
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [IN_W-1:0] in_data_i,
    input  logic            in_dval_i,
    output logic [Q_W-1:0]  q_out_o,
    output logic [R_W-1:0]  r_out_o,
    output logic            out_dval_o,
    output logic            sat_o,
    output logic            busy_o,
    output logic            drop_o,
    output logic [7:0]      drop_cnt_o
);

    localparam int unsigned IterW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [R_W:0] Div  = (R_W + 1)'(DIVISOR);

    if (DIVISOR == 0 || DIVISOR >= (2 ** R_W)) begin : g_bad_divisor
        $error("DIVISOR must be > 0 and < 2**R_W");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic [IN_W-1:0]   dvd_q;
    logic [IN_W-1:0]   quot_q;
    logic [R_W-1:0]    rem_q;
    logic [IterW-1:0]  iter_q;
    logic              pend_v_q;
    logic [IN_W-1:0]   pend_data_q;
    logic [Q_W-1:0]    q_out_q;
    logic [R_W-1:0]    r_out_q;
    logic              sat_q;
    logic              out_dval_q;
    logic              drop_q;
    logic [7:0]        drop_cnt_q;

    logic [R_W:0]      rem_shift;
    logic [R_W:0]      rem_sub;
    logic              rem_ge;
    logic [R_W-1:0]    rem_next;
    logic              load_en;
    logic [IN_W-1:0]   load_val;
    logic              sat_c;
    logic [Q_W-1:0]    q_sel;

    // One restoring step: partial remainder never reaches DIVISOR, so it
    // fits R_W bits after the conditional subtract.
    always_comb begin
        rem_shift = {rem_q, dvd_q[IN_W-1]};
        rem_ge    = (rem_shift >= Div);
        rem_sub   = rem_shift - Div;
        rem_next  = rem_ge ? rem_sub[R_W-1:0] : rem_shift[R_W-1:0];
    end

    // Pending sample always goes first to keep arrival order.
    always_comb begin
        load_en  = 1'b0;
        load_val = in_data_i;
        if (state_q == StIdle) begin
            if (pend_v_q) begin
                load_en  = 1'b1;
                load_val = pend_data_q;
            end else if (in_dval_i) begin
                load_en = 1'b1;
            end
        end
    end

    if (Q_W < IN_W) begin : g_sat
        assign sat_c = |quot_q[IN_W-1:Q_W];
        assign q_sel = sat_c ? {Q_W{1'b1}} : quot_q[Q_W-1:0];
    end else begin : g_nosat
        assign sat_c = 1'b0;
        assign q_sel = Q_W'(quot_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            dvd_q       <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            iter_q      <= '0;
            pend_v_q    <= 1'b0;
            pend_data_q <= '0;
            q_out_q     <= '0;
            r_out_q     <= '0;
            sat_q       <= 1'b0;
            out_dval_q  <= 1'b0;
            drop_q      <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            out_dval_q <= 1'b0;
            drop_q     <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (load_en) begin
                        dvd_q   <= load_val;
                        rem_q   <= '0;
                        quot_q  <= '0;
                        iter_q  <= IterW'(IN_W - 1);
                        state_q <= StRun;
                    end
                    if (pend_v_q) begin
                        pend_v_q <= in_dval_i;
                        if (in_dval_i) begin
                            pend_data_q <= in_data_i;
                        end
                    end
                end
                StRun: begin
                    dvd_q  <= {dvd_q[IN_W-2:0], 1'b0};
                    rem_q  <= rem_next;
                    quot_q <= {quot_q[IN_W-2:0], rem_ge};
                    iter_q <= iter_q - 1'b1;
                    if (iter_q == '0) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    q_out_q    <= q_sel;
                    r_out_q    <= rem_q;
                    sat_q      <= sat_c;
                    out_dval_q <= 1'b1;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            if (state_q != StIdle && in_dval_i) begin
                if (!pend_v_q) begin
                    pend_v_q    <= 1'b1;
                    pend_data_q <= in_data_i;
                end else begin
                    drop_q <= 1'b1;
                    if (drop_cnt_q != 8'hff) begin
                        drop_cnt_q <= drop_cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    assign q_out_o    = q_out_q;
    assign r_out_o    = r_out_q;
    assign sat_o      = sat_q;
    assign out_dval_o = out_dval_q;
    assign busy_o     = (state_q != StIdle);
    assign drop_o     = drop_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_tdc_div_x400.sv
module tb_tdc_div_x400;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [19:0] in_data_i = '0;
    logic        in_dval_i = 1'b0;

    logic [11:0] q_out;
    logic [8:0]  r_out;
    logic        out_dval, sat, busy, drop;
    logic [7:0]  drop_cnt;

    logic [10:0] q11;
    logic [8:0]  r11;
    logic        out_dval11, sat11, busy11, drop11;
    logic [7:0]  drop_cnt11;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    tdc_div_x400 dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_data_i  (in_data_i),
        .in_dval_i  (in_dval_i),
        .q_out_o    (q_out),
        .r_out_o    (r_out),
        .out_dval_o (out_dval),
        .sat_o      (sat),
        .busy_o     (busy),
        .drop_o     (drop),
        .drop_cnt_o (drop_cnt)
    );

    tdc_div_x400 #(.Q_W(11)) dut11 (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_data_i  (in_data_i),
        .in_dval_i  (in_dval_i),
        .q_out_o    (q11),
        .r_out_o    (r11),
        .out_dval_o (out_dval11),
        .sat_o      (sat11),
        .busy_o     (busy11),
        .drop_o     (drop11),
        .drop_cnt_o (drop_cnt11)
    );

    typedef struct {
        logic [19:0] din;
        int          q;
        int          r;
        int          s;
        int          q11;
        int          s11;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int exp_idx(input int k);
        if (k == 0) return 0;
        if (k == 1) return 1;
        return 22 * (k - 1);
    endfunction

    initial begin
        vt[0] = '{20'd410216,  1025, 216, 0, 1025, 0};
        vt[1] = '{20'd0,          0,   0, 0,    0, 0};
        vt[2] = '{20'd399,        0, 399, 0,    0, 0};
        vt[3] = '{20'd400,        1,   0, 0,    1, 0};
        vt[4] = '{20'd800,        2,   0, 0,    2, 0};
        vt[5] = '{20'd1201,       3,   1, 0,    3, 0};
        vt[6] = '{20'd1048575, 2621, 175, 0, 2047, 1};
        vt[7] = '{20'd1048000, 2620,   0, 0, 2047, 1};
        vt[8] = '{20'd160000,   400,   0, 0,  400, 0};

        // Reset state
        #12;
        chk("rst q_out", q_out, 0);
        chk("rst r_out", r_out, 0);
        chk("rst out_dval", out_dval, 0);
        chk("rst busy", busy, 0);
        chk("rst drop_cnt", drop_cnt, 0);
        tick();
        rst_ni = 1'b1;
        tick();
        tick();

        // Single samples: latency 21, busy 21 cycles, results hold afterwards
        for (int i = 0; i < 9; i++) begin
            in_data_i = vt[i].din;
            in_dval_i = 1'b1;
            tick();
            in_dval_i = 1'b0;
            chk("vec busy e0", busy, 1);
            for (int c = 1; c <= 21; c++) begin
                tick();
                if (c < 21) begin
                    chk("vec out_dval early", out_dval, 0);
                    chk("vec busy run", busy, 1);
                end
            end
            chk("vec out_dval", out_dval, 1);
            chk("vec busy done", busy, 0);
            chk("vec q", q_out, vt[i].q);
            chk("vec r", r_out, vt[i].r);
            chk("vec sat", sat, vt[i].s);
            chk("vec q11", q11, vt[i].q11);
            chk("vec r11", r11, vt[i].r);
            chk("vec sat11", sat11, vt[i].s11);
            for (int c = 0; c < 8; c++) tick();
            chk("vec hold out_dval", out_dval, 0);
            chk("vec hold q", q_out, vt[i].q);
            chk("vec hold r", r_out, vt[i].r);
        end

        // Back-to-back A, B, C: C dropped, B runs from pending
        in_data_i = 20'd800;  in_dval_i = 1'b1; tick();
        in_data_i = 20'd1201; tick();
        in_data_i = 20'd5;    tick();
        in_dval_i = 1'b0;
        chk("b2b drop pulse", drop, 1);
        chk("b2b drop_cnt", drop_cnt, 1);
        tick();
        chk("b2b drop low", drop, 0);
        for (int e = 4; e <= 50; e++) begin
            tick();
            if (e == 21) begin
                chk("b2b A dval", out_dval, 1);
                chk("b2b A q", q_out, 2);
                chk("b2b A r", r_out, 0);
            end else if (e == 43) begin
                chk("b2b B dval", out_dval, 1);
                chk("b2b B q", q_out, 3);
                chk("b2b B r", r_out, 1);
            end else begin
                chk("b2b no extra dval", out_dval, 0);
            end
        end
        chk("b2b drop_cnt hold", drop_cnt, 1);

        // Reset mid-run with pending valid
        in_data_i = 20'd12345; in_dval_i = 1'b1; tick();
        in_data_i = 20'd2800;  tick();
        in_dval_i = 1'b0;
        for (int e = 2; e <= 10; e++) tick();
        rst_ni = 1'b0;
        #1;
        chk("amid q_out", q_out, 0);
        chk("amid r_out", r_out, 0);
        chk("amid sat", sat, 0);
        chk("amid busy", busy, 0);
        chk("amid drop_cnt", drop_cnt, 0);
        chk("amid out_dval", out_dval, 0);
        tick();
        rst_ni = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            chk("post-rst no dval", out_dval, 0);
        end
        in_data_i = 20'd400; in_dval_i = 1'b1; tick();
        in_dval_i = 1'b0;
        for (int c = 1; c <= 21; c++) tick();
        chk("post-rst dval", out_dval, 1);
        chk("post-rst q", q_out, 1);
        chk("post-rst r", r_out, 0);
        for (int c = 0; c < 5; c++) tick();

        // Continuous stream: data = edge index; accepted 0, 1, 22, 44, ...
        begin
            int k;
            k = 0;
            in_data_i = 20'd0;
            in_dval_i = 1'b1;
            for (int e = 0; e <= 6035; e++) begin
                tick();
                if (e == 5999) in_dval_i = 1'b0;
                in_data_i = 20'(e + 1);
                chk("stream dval slot", out_dval, (e % 22 == 21) && (e <= 6027));
                if (out_dval) begin
                    chk("stream q", q_out, exp_idx(k) / 400);
                    chk("stream r", r_out, exp_idx(k) % 400);
                    chk("stream sat", sat, 0);
                    k++;
                end
            end
            chk("stream results", k, 274);
            chk("stream drop_cnt sat", drop_cnt, 255);
            chk("stream idle", busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
